// File: rtl/pellet_store.sv
// rtl/pellet_store.sv - pellet map: loads from maze ROM, serves eat requests, renders pellet dots
module pellet_store #(
  parameter int         COLS      = 27,
  parameter int         ROWS      = 24,
  parameter int         TILE_LOG2 = 4,
  parameter logic [9:0] X_ORG     = 10'd104,
  parameter logic [9:0] Y_ORG     = 10'd50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [4:0] maze_x,
  output logic [4:0] maze_y,
  input  logic       maze_wall,
  input  logic       eat_req,
  input  logic [9:0] eat_x,
  input  logic [9:0] eat_y,
  output logic       eat_ack,
  output logic       eat_hit,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic       bright,
  output logic       pellet_fill,
  output logic [9:0] remaining,
  output logic       all_eaten,
  output logic       busy
);

  localparam int NT = COLS * ROWS;
  localparam logic [9:0] COLS_W = 10'(COLS);
  localparam logic [9:0] ROWS_W = 10'(ROWS);
  localparam logic [9:0] NT_W   = 10'(NT);
  localparam logic [9:0] LAST_W = 10'(NT - 1);
  localparam logic [4:0] LAST_X = 5'(COLS - 1);
  localparam logic [TILE_LOG2-1:0] DOT_LO = TILE_LOG2'(6);
  localparam logic [TILE_LOG2-1:0] DOT_HI = TILE_LOG2'(9);

  typedef enum logic [1:0] {IDLE, INIT, READY} state_t;

  state_t         state;
  logic [NT-1:0]  map;
  logic [9:0]     cnt;

  logic [9:0] eat_col, eat_row, eat_idx;
  logic       eat_in, accept;
  logic [9:0] r_mx, r_my, r_col, r_row, r_idx;
  logic [TILE_LOG2-1:0] r_ox, r_oy;
  logic       render;

  assign eat_col = eat_x >> TILE_LOG2;
  assign eat_row = eat_y >> TILE_LOG2;
  assign eat_in  = (eat_col < COLS_W) && (eat_row < ROWS_W);
  assign eat_idx = 10'(eat_row * COLS + eat_col);
  // The ack cycle blocks re-acceptance, and a simultaneous start drops the request.
  assign accept  = (state == READY) && eat_req && !eat_ack && !start;

  assign r_mx   = hCount - X_ORG;
  assign r_my   = vCount - Y_ORG;
  assign r_col  = r_mx >> TILE_LOG2;
  assign r_row  = r_my >> TILE_LOG2;
  assign r_ox   = r_mx[TILE_LOG2-1:0];
  assign r_oy   = r_my[TILE_LOG2-1:0];
  assign r_idx  = 10'(r_row * COLS + r_col);
  assign render = bright && (r_col < COLS_W) && (r_row < ROWS_W) && map[r_idx] &&
                  (r_ox >= DOT_LO) && (r_ox <= DOT_HI) &&
                  (r_oy >= DOT_LO) && (r_oy <= DOT_HI);

  assign all_eaten = (state == READY) && (remaining == 10'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      map         <= '0;
      cnt         <= 10'd0;
      remaining   <= 10'd0;
      maze_x      <= 5'd0;
      maze_y      <= 5'd0;
      eat_ack     <= 1'b0;
      eat_hit     <= 1'b0;
      pellet_fill <= 1'b0;
      busy        <= 1'b0;
    end else begin
      eat_ack     <= 1'b0;
      eat_hit     <= 1'b0;
      pellet_fill <= render;
      if (start) begin
        state     <= INIT;
        busy      <= 1'b1;
        cnt       <= 10'd0;
        maze_x    <= 5'd0;
        maze_y    <= 5'd0;
        remaining <= 10'd0;
      end else begin
        case (state)
          INIT: begin
            // ROM data arriving now belongs to the address driven last cycle.
            if (cnt != 10'd0) begin
              map[cnt - 10'd1] <= ~maze_wall;
              remaining        <= remaining + {9'd0, ~maze_wall};
            end
            if (cnt == NT_W) begin
              state <= READY;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 10'd1;
              if (cnt < LAST_W) begin
                if (maze_x == LAST_X) begin
                  maze_x <= 5'd0;
                  maze_y <= maze_y + 5'd1;
                end else begin
                  maze_x <= maze_x + 5'd1;
                end
              end
            end
          end
          READY: begin
            if (accept) begin
              eat_ack <= 1'b1;
              if (eat_in && map[eat_idx]) begin
                eat_hit       <= 1'b1;
                map[eat_idx]  <= 1'b0;
                remaining     <= remaining - 10'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
